// File: rtl/hazard_scoreboard.sv
// Per-register write scoreboard for the ID stage: countdown to register-file write
// per architectural register, load-use stall and registered EX forwarding selects.
module hazard_scoreboard #(
   parameter  int NUM_REGS   = 8,
   parameter  int DEPTH      = 3,
   parameter  int LOAD_STAGE = 2,
   localparam int AW         = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1,
   localparam int CW         = $clog2(DEPTH + 1),
   localparam int SW         = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   input  logic                i_freeze,
   input  logic                i_flush,
   input  logic                i_id_valid,
   input  logic [AW-1:0]       i_id_rs,
   input  logic [AW-1:0]       i_id_rt,
   input  logic                i_id_rs_used,
   input  logic                i_id_rt_used,
   input  logic [AW-1:0]       i_id_rd,
   input  logic                i_id_wr,
   input  logic                i_id_load,
   output logic                o_stall,
   output logic                o_issue,
   output logic [SW-1:0]       o_ex_fwd_rs,
   output logic [SW-1:0]       o_ex_fwd_rt,
   output logic [NUM_REGS-1:0] o_busy,
   output logic                o_err
);

   logic [CW-1:0]       r_cnt [NUM_REGS];
   logic [NUM_REGS-1:0] r_ld;
   logic [SW-1:0]       r_fwd_rs;
   logic [SW-1:0]       r_fwd_rt;
   logic                r_err;

   logic [CW-1:0]       w_rs_cnt;
   logic [CW-1:0]       w_rt_cnt;
   logic                w_rs_ld;
   logic                w_rt_ld;
   logic                w_rs_hit;
   logic                w_rt_hit;
   logic                w_rd_hit;
   logic [SW:0]         w_haz_rs;
   logic [SW:0]         w_haz_rt;
   logic                w_stall;
   logic                w_issue;
   logic                w_idx_bad;

   // k = cycles until the producer's value is in the RF; the producer will sit in
   // post-EX stage j = DEPTH-k+1 next cycle. Returns {stall, fwd}.
   function automatic logic [SW:0] f_hazard(input logic i_used,
                                             input logic [CW-1:0] i_k,
                                             input logic i_ld);
      int            j;
      logic [SW-1:0] fwd;
      logic          st;
      fwd = '0;
      st  = 1'b0;
      j   = DEPTH - int'(i_k) + 1;
      if (i_used && (i_k != '0)) begin
         if (j != DEPTH) fwd = SW'(j);
         st = i_ld && (j < LOAD_STAGE);
      end
      return {st, fwd};
   endfunction

   // One-hot lookup; an index with no matching register reads as idle.
   always_comb begin
      w_rs_cnt = '0;
      w_rt_cnt = '0;
      w_rs_ld  = 1'b0;
      w_rt_ld  = 1'b0;
      w_rs_hit = 1'b0;
      w_rt_hit = 1'b0;
      w_rd_hit = 1'b0;
      for (int r = 0; r < NUM_REGS; r++) begin
         if (i_id_rs == AW'(r)) begin
            w_rs_cnt = r_cnt[r];
            w_rs_ld  = r_ld[r];
            w_rs_hit = 1'b1;
         end
         if (i_id_rt == AW'(r)) begin
            w_rt_cnt = r_cnt[r];
            w_rt_ld  = r_ld[r];
            w_rt_hit = 1'b1;
         end
         if (i_id_rd == AW'(r)) w_rd_hit = 1'b1;
      end
   end

   assign w_haz_rs  = f_hazard(i_id_rs_used, w_rs_cnt, w_rs_ld);
   assign w_haz_rt  = f_hazard(i_id_rt_used, w_rt_cnt, w_rt_ld);
   assign w_stall   = i_id_valid & ~i_flush & (w_haz_rs[SW] | w_haz_rt[SW]);
   assign w_issue   = i_id_valid & ~w_stall & ~i_flush & ~i_freeze;
   assign w_idx_bad = (i_id_rs_used & ~w_rs_hit) | (i_id_rt_used & ~w_rt_hit) |
                      (i_id_wr & ~w_rd_hit);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int r = 0; r < NUM_REGS; r++) begin
            r_cnt[r] <= '0;
         end
         r_ld     <= '0;
         r_fwd_rs <= '0;
         r_fwd_rt <= '0;
         r_err    <= 1'b0;
      end else if (!i_freeze) begin
         // A new write to a register restarts its countdown (youngest writer wins).
         for (int r = 0; r < NUM_REGS; r++) begin
            if (w_issue && i_id_wr && (i_id_rd == AW'(r))) begin
               r_cnt[r] <= CW'(DEPTH);
               r_ld[r]  <= i_id_load;
            end else if (r_cnt[r] != '0) begin
               r_cnt[r] <= r_cnt[r] - CW'(1);
            end
         end
         r_fwd_rs <= w_issue ? w_haz_rs[SW-1:0] : '0;
         r_fwd_rt <= w_issue ? w_haz_rt[SW-1:0] : '0;
         if (w_issue && w_idx_bad) r_err <= 1'b1;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REGS; gi++) begin : g_busy
         assign o_busy[gi] = (r_cnt[gi] != '0);
      end
   endgenerate

   assign o_stall     = w_stall;
   assign o_issue     = w_issue;
   assign o_ex_fwd_rs = r_fwd_rs;
   assign o_ex_fwd_rt = r_fwd_rt;
   assign o_err       = r_err;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed pipeline scenarios plus randomized traffic
// checked against an in-flight instruction history model.
module tb_hazard_scoreboard;

   localparam int NUM_REGS   = 8;
   localparam int DEPTH      = 3;
   localparam int LOAD_STAGE = 2;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       freeze = 1'b0, flush = 1'b0, id_valid = 1'b0;
   logic [2:0] id_rs = '0, id_rt = '0, id_rd = '0;
   logic       id_rs_used = 1'b0, id_rt_used = 1'b0, id_wr = 1'b0, id_load = 1'b0;
   logic       o_stall, o_issue, o_err;
   logic [1:0] o_fwd_rs, o_fwd_rt;
   logic [7:0] o_busy;

   int n_vec = 0;
   int n_err = 0;

   // History model: every issued write still on its way to the register file,
   // with the number of unfrozen edges since it issued.
   typedef struct {
      int rd;
      bit ld;
      int age;
   } wr_t;
   wr_t mq[$];
   int  m_fwd_rs = 0;
   int  m_fwd_rt = 0;

   hazard_scoreboard #(.NUM_REGS(NUM_REGS), .DEPTH(DEPTH), .LOAD_STAGE(LOAD_STAGE)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_freeze(freeze), .i_flush(flush),
      .i_id_valid(id_valid), .i_id_rs(id_rs), .i_id_rt(id_rt),
      .i_id_rs_used(id_rs_used), .i_id_rt_used(id_rt_used), .i_id_rd(id_rd),
      .i_id_wr(id_wr), .i_id_load(id_load), .o_stall(o_stall), .o_issue(o_issue),
      .o_ex_fwd_rs(o_fwd_rs), .o_ex_fwd_rt(o_fwd_rt), .o_busy(o_busy), .o_err(o_err)
   );

   always #5 clk = ~clk;

   // The youngest in-flight writer of a source is age edges past issue, so it is
   // in post-EX stage 'age' next cycle; stage DEPTH is the RF write itself.
   function automatic void mdl_src(input bit used, input int idx, output bit st, output int fw);
      int best = DEPTH + 1;
      bit bld = 0;
      st = 0;
      fw = 0;
      if (!used) return;
      foreach (mq[i]) if (mq[i].rd == idx && mq[i].age < best) begin
         best = mq[i].age;
         bld  = mq[i].ld;
      end
      if (best <= DEPTH) begin
         fw = (best == DEPTH) ? 0 : best;
         st = bld && (best < LOAD_STAGE);
      end
   endfunction

   function automatic logic [7:0] mdl_busy();
      logic [7:0] b = '0;
      foreach (mq[i]) b[mq[i].rd] = 1'b1;
      return b;
   endfunction

   task automatic set_id(input bit v, input int rs, input bit rsu, input int rt, input bit rtu,
                         input int rd, input bit wr, input bit ld);
      id_valid = v; id_rs = 3'(rs); id_rs_used = rsu; id_rt = 3'(rt); id_rt_used = rtu;
      id_rd = 3'(rd); id_wr = wr; id_load = ld;
   endtask

   task automatic idle();
      set_id(0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      idle();
      freeze = 0;
      flush  = 0;
      rst_n  = 0;
      mq.delete();
      m_fwd_rs = 0;
      m_fwd_rt = 0;
      step();
      rst_n = 1;
   endtask

   task automatic test_reset();
      do_reset();
      set_id(1, 1, 1, 2, 1, 3, 1, 1);
      #1;
      n_vec++; if (o_busy !== 8'h00) begin n_err++; $display("FAIL reset_busy: got %h want 00", o_busy); end
      n_vec++; if (o_fwd_rs !== 2'd0 || o_fwd_rt !== 2'd0) begin n_err++; $display("FAIL reset_fwd: got %0d/%0d want 0/0", o_fwd_rs, o_fwd_rt); end
      n_vec++; if (o_err !== 1'b0) begin n_err++; $display("FAIL reset_err: got %b want 0", o_err); end
      n_vec++; if (o_stall !== 1'b0 || o_issue !== 1'b1) begin n_err++; $display("FAIL reset_stall_issue: got %b/%b want 0/1", o_stall, o_issue); end
      $display("test_reset done");
      idle();
   endtask

   task automatic test_alu_forward();
      do_reset();
      set_id(1, 0, 0, 0, 0, 3, 1, 0);
      step();
      set_id(1, 3, 1, 0, 0, 0, 0, 0);
      #1;
      n_vec++; if (o_stall !== 1'b0 || o_issue !== 1'b1) begin n_err++; $display("FAIL alu_stall_issue: got %b/%b want 0/1", o_stall, o_issue); end
      step();
      idle();
      n_vec++; if (o_fwd_rs !== 2'd1) begin n_err++; $display("FAIL alu_fwd_rs: got %0d want 1", o_fwd_rs); end
      $display("test_alu_forward done");
   endtask

   task automatic test_load_use();
      do_reset();
      set_id(1, 0, 0, 0, 0, 2, 1, 1);
      step();
      set_id(1, 0, 0, 2, 1, 5, 1, 0);
      #1;
      n_vec++; if (o_stall !== 1'b1 || o_issue !== 1'b0) begin n_err++; $display("FAIL lu_stall1: got %b/%b want 1/0", o_stall, o_issue); end
      step();
      n_vec++; if (o_stall !== 1'b0 || o_issue !== 1'b1) begin n_err++; $display("FAIL lu_stall2: got %b/%b want 0/1", o_stall, o_issue); end
      n_vec++; if (o_fwd_rt !== 2'd0) begin n_err++; $display("FAIL lu_bubble: got %0d want 0", o_fwd_rt); end
      step();
      idle();
      n_vec++; if (o_fwd_rt !== 2'd2) begin n_err++; $display("FAIL lu_fwd_rt: got %0d want 2", o_fwd_rt); end
      $display("test_load_use done");
   endtask

   task automatic test_distance();
      do_reset();
      set_id(1, 0, 0, 0, 0, 4, 1, 0);
      step();
      idle();
      step();
      set_id(1, 4, 1, 0, 0, 0, 0, 0);
      step();
      n_vec++; if (o_fwd_rs !== 2'd2) begin n_err++; $display("FAIL dist2_fwd: got %0d want 2", o_fwd_rs); end
      n_vec++; if (o_busy[4] !== 1'b1) begin n_err++; $display("FAIL dist3_busy: got %b want 1", o_busy[4]); end
      step();
      n_vec++; if (o_fwd_rs !== 2'd0) begin n_err++; $display("FAIL dist3_fwd: got %0d want 0", o_fwd_rs); end
      n_vec++; if (o_busy[4] !== 1'b0) begin n_err++; $display("FAIL dist_busy_clear: got %b want 0", o_busy[4]); end
      step();
      idle();
      n_vec++; if (o_fwd_rs !== 2'd0) begin n_err++; $display("FAIL dist4_fwd: got %0d want 0", o_fwd_rs); end
      $display("test_distance done");
   endtask

   task automatic test_freeze();
      do_reset();
      set_id(1, 0, 0, 0, 0, 5, 1, 0);
      step();
      set_id(1, 5, 1, 0, 0, 0, 0, 0);
      step();
      freeze = 1;
      for (int c = 0; c < 5; c++) begin
         #1;
         n_vec++; if (o_issue !== 1'b0) begin n_err++; $display("FAIL frz_issue[%0d]: got %b want 0", c, o_issue); end
         n_vec++; if (o_fwd_rs !== 2'd1 || o_busy !== 8'h20) begin n_err++; $display("FAIL frz_hold[%0d]: fwd %0d busy %h want 1 20", c, o_fwd_rs, o_busy); end
         step();
      end
      freeze = 0;
      #1;
      n_vec++; if (o_issue !== 1'b1) begin n_err++; $display("FAIL frz_release_issue: got %b want 1", o_issue); end
      step();
      n_vec++; if (o_fwd_rs !== 2'd2) begin n_err++; $display("FAIL frz_resume_fwd: got %0d want 2", o_fwd_rs); end
      step();
      idle();
      n_vec++; if (o_fwd_rs !== 2'd0 || o_busy[5] !== 1'b0) begin n_err++; $display("FAIL frz_resume_done: fwd %0d busy %b want 0 0", o_fwd_rs, o_busy[5]); end
      $display("test_freeze done");
   endtask

   task automatic test_waw();
      do_reset();
      set_id(1, 0, 0, 0, 0, 1, 1, 1);
      step();
      set_id(1, 0, 0, 0, 0, 1, 1, 0);
      step();
      set_id(1, 1, 1, 0, 0, 0, 0, 0);
      #1;
      n_vec++; if (o_stall !== 1'b0) begin n_err++; $display("FAIL waw_stall: got %b want 0", o_stall); end
      step();
      idle();
      n_vec++; if (o_fwd_rs !== 2'd1) begin n_err++; $display("FAIL waw_fwd: got %0d want 1", o_fwd_rs); end
      $display("test_waw done");
   endtask

   task automatic test_async_reset();
      do_reset();
      set_id(1, 0, 0, 0, 0, 6, 1, 0);
      step();
      set_id(1, 6, 1, 0, 0, 2, 1, 1);
      step();
      idle();
      n_vec++; if (o_fwd_rs !== 2'd1 || o_busy !== 8'h44) begin n_err++; $display("FAIL arst_pre: fwd %0d busy %h want 1 44", o_fwd_rs, o_busy); end
      #2;
      rst_n = 0;
      #1;
      n_vec++; if (o_busy !== 8'h00 || o_fwd_rs !== 2'd0 || o_fwd_rt !== 2'd0 || o_err !== 1'b0) begin
         n_err++; $display("FAIL arst_clear: busy %h fwd %0d/%0d err %b want 00 0/0 0", o_busy, o_fwd_rs, o_fwd_rt, o_err);
      end
      #2;
      rst_n = 1;
      set_id(1, 0, 0, 2, 1, 0, 0, 0);
      #1;
      n_vec++; if (o_stall !== 1'b0 || o_issue !== 1'b1) begin n_err++; $display("FAIL arst_no_stale: got %b/%b want 0/1", o_stall, o_issue); end
      step();
      idle();
      mq.delete();
      $display("test_async_reset done");
   endtask

   task automatic test_random();
      bit s1, s2, e_stall, e_issue;
      int f1, f2;
      wr_t nq[$];
      do_reset();
      for (int c = 0; c < 400; c++) begin
         set_id($urandom_range(0, 9) < 8,
                ($urandom_range(0, 1) != 0) ? $urandom_range(0, 3) : $urandom_range(0, 7),
                $urandom_range(0, 3) != 0,
                ($urandom_range(0, 1) != 0) ? $urandom_range(0, 3) : $urandom_range(0, 7),
                $urandom_range(0, 3) != 0,
                $urandom_range(0, 3), $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0);
         freeze = ($urandom_range(0, 9) == 0);
         flush  = ($urandom_range(0, 11) == 0);
         #1;
         mdl_src(id_rs_used, int'(id_rs), s1, f1);
         mdl_src(id_rt_used, int'(id_rt), s2, f2);
         e_stall = id_valid && !flush && (s1 || s2);
         e_issue = id_valid && !e_stall && !flush && !freeze;
         n_vec++; if (o_stall !== e_stall || o_issue !== e_issue) begin
            n_err++; $display("FAIL rnd_stall_issue[%0d]: got %b/%b want %b/%b", c, o_stall, o_issue, e_stall, e_issue);
         end
         n_vec++; if (o_fwd_rs !== 2'(m_fwd_rs) || o_fwd_rt !== 2'(m_fwd_rt)) begin
            n_err++; $display("FAIL rnd_fwd[%0d]: got %0d/%0d want %0d/%0d", c, o_fwd_rs, o_fwd_rt, m_fwd_rs, m_fwd_rt);
         end
         n_vec++; if (o_busy !== mdl_busy() || o_err !== 1'b0) begin
            n_err++; $display("FAIL rnd_busy_err[%0d]: got %h/%b want %h/0", c, o_busy, o_err, mdl_busy());
         end
         if (!freeze) begin
            nq.delete();
            foreach (mq[i]) if (mq[i].age < DEPTH) nq.push_back('{mq[i].rd, mq[i].ld, mq[i].age + 1});
            if (e_issue && id_wr) nq.push_back('{int'(id_rd), id_load, 1});
            mq = nq;
            m_fwd_rs = e_issue ? f1 : 0;
            m_fwd_rt = e_issue ? f2 : 0;
         end
         step();
      end
      idle();
      freeze = 0;
      flush  = 0;
      $display("test_random done");
   endtask

   initial begin
      test_reset();
      test_alu_forward();
      test_load_use();
      test_distance();
      test_freeze();
      test_waw();
      test_async_reset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
